// File: rtl/vpu_dst_port_if.sv
// Bundle of the command, ALU result and VRF write handshakes seen by vpu_dst_port.
// slave is the collector's view; master is the environment (controller, ALU, VRF).
interface vpu_dst_port_if #(
  parameter int OPERAND_WIDTH  = 32,
  parameter int ELEMS_PER_WORD = 4,
  parameter int ADDR_WIDTH     = 5
);
  logic                                    start_i;
  logic [ADDR_WIDTH-1:0]                   dst_addr_i;
  logic [7:0]                              elem_cnt_i;
  logic                                    busy_o;
  logic                                    res_valid_i;
  logic [OPERAND_WIDTH-1:0]                res_i;
  logic                                    res_ready_o;
  logic                                    wr_valid_o;
  logic                                    wr_ready_i;
  logic [ADDR_WIDTH-1:0]                   wr_addr_o;
  logic [OPERAND_WIDTH*ELEMS_PER_WORD-1:0] wr_data_o;
  logic [ELEMS_PER_WORD-1:0]               wr_mask_o;
  logic                                    done_o;

  modport slave (
    input  start_i, dst_addr_i, elem_cnt_i, res_valid_i, res_i, wr_ready_i,
    output busy_o, res_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_mask_o, done_o
  );

  modport master (
    output start_i, dst_addr_i, elem_cnt_i, res_valid_i, res_i, wr_ready_i,
    input  busy_o, res_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_mask_o, done_o
  );
endinterface

// File: rtl/vpu_dst_port.sv
// VPU destination port: packs ALU results into masked VRF words, buffers completed
// words in a small FIFO and writes them at incrementing addresses, then pulses done.

// One staging lane. data_o/mask_o show the lane as it would look with this cycle's
// element included, so a completing word can be pushed without waiting a cycle.
module vpu_dst_lane #(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     load_i,
  input  logic [OPERAND_WIDTH-1:0] res_i,
  output logic [OPERAND_WIDTH-1:0] data_o,
  output logic                     mask_o
);
  logic [OPERAND_WIDTH-1:0] data_q, data_d;
  logic                     mask_q, mask_d;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (clr_i) begin
      data_d = '0;
      mask_d = 1'b0;
    end else if (load_i) begin
      data_d = res_i;
      mask_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      mask_q <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign data_o = load_i ? res_i : data_q;
  assign mask_o = load_i | mask_q;
endmodule

module vpu_dst_port #(
  parameter int OPERAND_WIDTH  = 32,
  parameter int ELEMS_PER_WORD = 4,
  parameter int ADDR_WIDTH     = 5,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic           clk,
  input  logic           rst,
  vpu_dst_port_if.slave  bus
);
  localparam int LP_W = (ELEMS_PER_WORD > 1) ? $clog2(ELEMS_PER_WORD) : 1;
  localparam int FP_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]                         addr;
    logic [ELEMS_PER_WORD-1:0]                     mask;
    logic [ELEMS_PER_WORD-1:0][OPERAND_WIDTH-1:0]  data;
  } wr_ent_t;

  state_t                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic [7:0]                        rem_q, rem_d;
  logic [LP_W-1:0]                   lane_ptr_q, lane_ptr_d;
  wr_ent_t [FIFO_DEPTH-1:0]          fifo_q, fifo_d;
  logic [FP_W-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [FP_W-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [FC_W-1:0]                   fcnt_q, fcnt_d;

  logic                                         start_acc, accept, complete, push, pop;
  logic                                         wr_valid, lane_clr;
  logic [ELEMS_PER_WORD-1:0]                    lane_load;
  logic [ELEMS_PER_WORD-1:0][OPERAND_WIDTH-1:0] word_data;
  logic [ELEMS_PER_WORD-1:0]                    word_mask;
  wr_ent_t                                      push_ent, head;

  function automatic logic [FP_W-1:0] ptr_inc(input logic [FP_W-1:0] p);
    return (p == FP_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = (bus.elem_cnt_i == 8'd0) ? DONE : COLLECT;
      COLLECT: if (push && rem_q == 8'd1) state_d = DRAIN;
      DRAIN:   if (fcnt_q == '0 || (fcnt_q == FC_W'(1) && pop)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o      = (state_q != IDLE);
    bus.done_o      = (state_q == DONE);
    bus.res_ready_o = (state_q == COLLECT) && (fcnt_q < FC_W'(FIFO_DEPTH));
  end

  // ---------------- handshakes ----------------
  assign start_acc = (state_q == IDLE) && bus.start_i;
  assign accept    = bus.res_valid_i && bus.res_ready_o;
  // A word closes on its last lane or on the command's last element.
  assign complete  = accept && (lane_ptr_q == LP_W'(ELEMS_PER_WORD - 1) || rem_q == 8'd1);
  assign push      = complete;
  assign wr_valid  = (fcnt_q != '0);
  assign pop       = wr_valid && bus.wr_ready_i;
  assign lane_clr  = start_acc || complete;

  // ---------------- staging lanes ----------------
  for (genvar g = 0; g < ELEMS_PER_WORD; g++) begin : g_sel
    assign lane_load[g] = accept && (lane_ptr_q == LP_W'(g));
  end

  vpu_dst_lane #(.OPERAND_WIDTH(OPERAND_WIDTH)) u_lane [ELEMS_PER_WORD-1:0] (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (lane_clr),
    .load_i (lane_load),
    .res_i  (bus.res_i),
    .data_o (word_data),
    .mask_o (word_mask)
  );

  always_comb begin
    push_ent      = '0;
    push_ent.addr = addr_q;
    push_ent.mask = word_mask;
    push_ent.data = word_data;
  end

  // ---------------- counters, address, FIFO ----------------
  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    lane_ptr_d = lane_ptr_q;
    if (start_acc) begin
      addr_d     = bus.dst_addr_i;
      rem_d      = bus.elem_cnt_i;
      lane_ptr_d = '0;
    end else if (accept) begin
      rem_d      = rem_q - 8'd1;
      lane_ptr_d = complete ? '0 : lane_ptr_q + 1'b1;
      if (complete) addr_d = addr_q + 1'b1;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_ent;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      lane_ptr_q <= '0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      lane_ptr_q <= lane_ptr_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Head fields are zeroed while empty so stale entries never show on the bus.
  assign head           = fifo_q[rd_ptr_q];
  assign bus.wr_valid_o = wr_valid;
  assign bus.wr_addr_o  = wr_valid ? head.addr : '0;
  assign bus.wr_mask_o  = wr_valid ? head.mask : '0;
  assign bus.wr_data_o  = wr_valid ? head.data : '0;
endmodule

// File: tb/tb_vpu_dst_port.sv
// Directed bench for vpu_dst_port: expected VRF writes are queued at command start
// and checked against every write handshake seen on the bus.
module tb_vpu_dst_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vpu_dst_port_if #(.OPERAND_WIDTH(32), .ELEMS_PER_WORD(4), .ADDR_WIDTH(5)) bus ();

  vpu_dst_port #(.OPERAND_WIDTH(32), .ELEMS_PER_WORD(4), .ADDR_WIDTH(5), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]   addr;
    logic [3:0]   mask;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   wr_cnt   = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the writes a command of cnt elements valued base, base+1, ... must produce.
  task automatic expect_cmd(input int a, input int cnt, input int base);
    exp_t e;
    for (int w = 0; w < (cnt + 3) / 4; w++) begin
      e.addr = 5'(a + w);
      e.mask = '0;
      e.data = '0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < cnt) begin
          e.mask[k]          = 1'b1;
          e.data[k*32 +: 32] = 32'(base + w * 4 + k);
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic start_cmd(input int a, input int cnt);
    bus.dst_addr_i = 5'(a);
    bus.elem_cnt_i = 8'(cnt);
    bus.start_i    = 1'b1;
    tick();
    bus.start_i    = 1'b0;
  endtask

  // Offer n elements valued base.., holding each until accepted; bounded by maxcyc.
  task automatic send(input int base, input int n, input int maxcyc, output int acc, output int cyc);
    logic taking;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < maxcyc) begin
      bus.res_valid_i = 1'b1;
      bus.res_i       = 32'(base + acc);
      taking          = bus.res_ready_o;
      tick();
      if (taking) acc++;
      cyc++;
    end
    bus.res_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxcyc);
    logic seen = 1'b0;
    for (int i = 0; i < maxcyc && !seen; i++) begin
      if (bus.done_o) seen = 1'b1;
      else tick();
    end
    chk(tag, seen, 1'b1);
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done_o) done_cnt++;
      if (bus.wr_valid_o && bus.wr_ready_i) begin
        wr_cnt++;
        chk("wr_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("wr_addr", bus.wr_addr_o, mon_e.addr);
          chk("wr_mask", bus.wr_mask_o, mon_e.mask);
          chk("wr_data", bus.wr_data_o, mon_e.data);
        end
      end
    end
  end

  initial begin
    int acc, cyc, w0, d0;
    logic [127:0] hd;
    bus.start_i = 0; bus.dst_addr_i = 0; bus.elem_cnt_i = 0;
    bus.res_valid_i = 0; bus.res_i = 0; bus.wr_ready_i = 1;

    // reset state
    tick();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ready", bus.res_ready_o, 0);
    chk("rst_wr_valid", bus.wr_valid_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_head", {bus.wr_addr_o, bus.wr_mask_o, bus.wr_data_o}, 0);
    rst = 1'b0;
    tick();

    // single full word, exact cycle timing
    w0 = wr_cnt; d0 = done_cnt;
    expect_cmd(3, 4, 1);
    start_cmd(3, 4);
    chk("t1_busy", bus.busy_o, 1);
    chk("t1_ready", bus.res_ready_o, 1);
    send(1, 4, 10, acc, cyc);
    chk("t1_b2b_cycles", cyc, 4);
    chk("t1_wr_valid", bus.wr_valid_o, 1);
    tick();
    chk("t1_done", bus.done_o, 1);
    tick();
    chk("t1_done_clr", bus.done_o, 0);
    chk("t1_busy_low", bus.busy_o, 0);
    chk("t1_writes", wr_cnt - w0, 1);
    chk("t1_dones", done_cnt - d0, 1);

    // full word plus partial word
    w0 = wr_cnt; d0 = done_cnt;
    expect_cmd(3, 6, 10);
    start_cmd(3, 6);
    send(10, 6, 20, acc, cyc);
    chk("t2_acc", acc, 6);
    wait_done("t2_done", 20);
    chk("t2_writes", wr_cnt - w0, 2);
    chk("t2_dones", done_cnt - d0, 1);

    // backpressure: FIFO fills after two words, head holds
    w0 = wr_cnt; d0 = done_cnt;
    bus.wr_ready_i = 1'b0;
    expect_cmd(8, 12, 'h100);
    start_cmd(8, 12);
    send('h100, 12, 20, acc, cyc);
    hd = {32'h103, 32'h102, 32'h101, 32'h100};
    chk("t3_acc_cap", acc, 8);
    chk("t3_ready_low", bus.res_ready_o, 0);
    chk("t3_wr_valid", bus.wr_valid_o, 1);
    chk("t3_head_addr", bus.wr_addr_o, 8);
    tick(); tick(); tick();
    chk("t3_head_addr_hold", bus.wr_addr_o, 8);
    chk("t3_head_data_hold", bus.wr_data_o, hd);
    chk("t3_head_mask_hold", bus.wr_mask_o, 4'hf);
    bus.wr_ready_i = 1'b1;
    send('h108, 4, 20, acc, cyc);
    chk("t3_acc_rest", acc, 4);
    wait_done("t3_done", 20);
    chk("t3_writes", wr_cnt - w0, 3);
    chk("t3_dones", done_cnt - d0, 1);

    // address wrap, with an ignored start while collecting
    w0 = wr_cnt; d0 = done_cnt;
    expect_cmd(31, 8, 'h200);
    start_cmd(31, 8);
    bus.dst_addr_i = 5; bus.elem_cnt_i = 1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("t4_busy", bus.busy_o, 1);
    send('h200, 8, 20, acc, cyc);
    wait_done("t4_done", 20);
    chk("t4_writes", wr_cnt - w0, 2);
    chk("t4_dones", done_cnt - d0, 1);

    // zero-length command, start during DONE ignored
    w0 = wr_cnt; d0 = done_cnt;
    start_cmd(2, 0);
    chk("t5_done", bus.done_o, 1);
    bus.dst_addr_i = 7; bus.elem_cnt_i = 4; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("t5_done_clr", bus.done_o, 0);
    chk("t5_idle", bus.busy_o, 0);
    tick();
    chk("t5_still_idle", bus.busy_o, 0);
    chk("t5_no_wr", bus.wr_valid_o, 0);
    chk("t5_writes", wr_cnt - w0, 0);
    chk("t5_dones", done_cnt - d0, 1);

    // reset mid-collect
    w0 = wr_cnt; d0 = done_cnt;
    start_cmd(9, 4);
    send('h300, 2, 10, acc, cyc);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_busy", bus.busy_o, 0);
    chk("t6_rst_ready", bus.res_ready_o, 0);
    chk("t6_rst_wr", bus.wr_valid_o, 0);
    chk("t6_rst_done", bus.done_o, 0);
    chk("t6_rst_head", {bus.wr_addr_o, bus.wr_mask_o, bus.wr_data_o}, 0);
    tick();
    rst = 1'b0;
    tick();
    expect_cmd(0, 4, 'h400);
    start_cmd(0, 4);
    send('h400, 4, 10, acc, cyc);
    wait_done("t6_done", 20);
    chk("t6_writes", wr_cnt - w0, 1);
    chk("t6_dones", done_cnt - d0, 1);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vpu_dst_port.md
# vpu_dst_port

Destination-side collector for VPU ALU results, sitting between the FP/INT ALU result outputs and the vector register file (VRF) write port. It accepts one OPERAND_WIDTH result per handshake. It packs consecutive results into VRF-wide words of ELEMS_PER_WORD lanes and buffers completed words in a small FIFO. It issues masked VRF writes at incrementing addresses and pulses done once every element of the command has been written.

## Interface
Parameters:
- OPERAND_WIDTH, 32, width of one ALU result element (VPU_PKG::OPERAND_WIDTH)
- ELEMS_PER_WORD, 4, lanes per VRF write word (power of 2)
- ADDR_WIDTH, 5, VRF word address width
- FIFO_DEPTH, 2, completed-word buffer entries

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  command strobe from VPU_CONTROLLER
- dst_addr_i  in  ADDR_WIDTH  first VRF word address
- elem_cnt_i  in  8  number of elements to collect, 0..255
- busy_o  out  1  command in progress
- res_valid_i  in  1  ALU result valid
- res_i  in  OPERAND_WIDTH  ALU result element
- res_ready_o  out  1  port can accept a result
- wr_valid_o  out  1  VRF write request
- wr_ready_i  in  1  VRF accepts write
- wr_addr_o  out  ADDR_WIDTH  VRF word address
- wr_data_o  out  OPERAND_WIDTH*ELEMS_PER_WORD  packed word, lane 0 at LSBs
- wr_mask_o  out  ELEMS_PER_WORD  per-lane write enable
- done_o  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, COLLECT, DRAIN, DONE.
- IDLE: start_i latches dst_addr_i into the address register and elem_cnt_i into the remaining counter. It also clears lane_ptr and the staging word.
  - elem_cnt_i≠0 -> COLLECT.
  - elem_cnt_i=0 -> DONE.
- start_i outside IDLE is ignored.
- COLLECT: res_ready_o = (FIFO count < FIFO_DEPTH). Outside COLLECT, res_ready_o = 0.
- Each accepted element (res_valid_i & res_ready_o):
  - the element is written to lane lane_ptr and that mask bit is set;
  - lane_ptr increments;
  - remaining decrements.
- Word completion: the element completes a word when lane_ptr = ELEMS_PER_WORD-1 or remaining = 1. On completion:
  - {staged word including this element, mask, address} is pushed into the FIFO;
  - the staging word and mask are cleared and lane_ptr returns to 0;
  - the address increments modulo 2^ADDR_WIDTH (31 -> 0).
- Partial last word: unfilled lanes carry data 0 and mask 0.
- After the final element is pushed -> DRAIN.
- DRAIN: when the FIFO becomes empty (including via a pop this cycle) -> DONE.
- DONE: done_o = 1 for exactly this cycle -> IDLE.
- FIFO:
  - wr_valid_o = FIFO not empty;
  - wr_addr_o, wr_data_o and wr_mask_o present the head entry;
  - the head is popped on wr_valid_o & wr_ready_i;
  - a push and a pop in the same cycle are allowed;
  - a push never occurs when full, because res_ready_o is low;
  - entries leave in push order.
- Head outputs remain stable while wr_valid_o=1 and wr_ready_i=0.
- busy_o = (state ≠ IDLE).

## Timing
- Reset (async assert, state takes effect immediately):
  - FSM to IDLE, FIFO empty, counters and address 0;
  - busy_o, res_ready_o, wr_valid_o, done_o = 0;
  - wr_addr_o, wr_data_o, wr_mask_o = 0.
- Reset mid-operation discards staged and buffered data. No write or done is produced for the aborted command.
- Start in cycle N:
  - busy_o high and state COLLECT (or DONE) from cycle N+1;
  - res_ready_o can be high from N+1.
- An element completing a word, accepted in cycle N, makes wr_valid_o high in cycle N+1 when the FIFO was empty.
- Back-to-back: one element per cycle is sustained while wr_ready_i=1.
- Final pop handshake in cycle M: done_o high in cycle M+1, busy_o low from M+2.
- elem_cnt_i=0 with start in cycle N: done_o high in N+1, no write issued.
- Backpressure: with wr_ready_i held 0, at most FIFO_DEPTH*ELEMS_PER_WORD elements are accepted, then res_ready_o stays 0.
- The FIFO count stays within 0..FIFO_DEPTH.

## Test plan
- start addr=3, cnt=4; results 1,2,3,4 back-to-back; wr_ready_i=1 -> exactly one write.
  - addr=3, data={4,3,2,1}, mask=4'b1111, wr_valid_o high the cycle after the 4th element.
  - done_o one cycle after the pop; busy_o low the cycle after that.
- start addr=3, cnt=6; results 10..15 -> write addr 3 {13,12,11,10} mask 1111, then write addr 4 {0,0,15,14} mask 0011, then a single done_o.
- start cnt=12, wr_ready_i=0 -> res_ready_o drops after 8 accepted elements with wr_valid_o=1 and head stable. Releasing wr_ready_i then:
  - drains addresses in order;
  - accepts the remaining 4 elements;
  - produces 3 writes total, then done_o.
- start addr=31, cnt=8 -> writes at addr 31 then addr 0.
- start cnt=0 -> done_o the next cycle, no wr_valid_o, back in IDLE. A start_i pulsed while busy is ignored (no extra writes).
- Assert rst mid-COLLECT after 2 elements -> all outputs 0 immediately. A new start addr=0, cnt=4 afterwards yields exactly one clean write and done_o.
